// File: rtl/seq_divider32.sv
// Iterative restoring radix-2 divider: one quotient bit per clock, signed or unsigned.
// Results, done and busy come from an output register stage, so done appears WIDTH+2 edges after start.
module seq_divider32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [WIDTH-1:0]   rem_r;
  logic [WIDTH-1:0]   q_r;
  logic [WIDTH-1:0]   d_r;
  logic [WIDTH-1:0]   dividend_r;
  logic               sign_q_r;
  logic               sign_r_r;
  logic [CNT_W-1:0]   count_r;
  logic               calc_busy_r;
  logic               res_done_r;
  logic               res_dbz_r;
  logic [WIDTH-1:0]   res_q_r;
  logic [WIDTH-1:0]   res_rem_r;

  logic               accept_s;
  logic               neg_a_s;
  logic               neg_b_s;
  logic [WIDTH:0]     rem_sh_s;
  logic [WIDTH:0]     trial_s;
  logic               trial_ok_s;
  logic               dbz_s;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
    magnitude = neg ? -v : v;
  endfunction

  // The output busy still shows the finishing operation for one cycle after the FSM is back in IDLE.
  assign accept_s   = (state_r == IDLE) && start && !busy;
  assign neg_a_s    = signed_op & dividend[WIDTH-1];
  assign neg_b_s    = signed_op & divisor[WIDTH-1];
  // R < D always holds, so R fits in WIDTH bits; the shifted value needs WIDTH+1.
  assign rem_sh_s   = {rem_r, q_r[WIDTH-1]};
  assign trial_s    = rem_sh_s - {1'b0, d_r};
  assign trial_ok_s = ~trial_s[WIDTH];
  assign dbz_s      = (d_r == {WIDTH{1'b0}});

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = CALC;
        else          state_s = IDLE;
      end
      CALC: begin
        if (count_r == {CNT_W{1'b0}}) state_s = FIX;
        else                          state_s = CALC;
      end
      FIX:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Operand capture, shift-subtract iteration and sign fix-up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_r       <= {WIDTH{1'b0}};
      q_r         <= {WIDTH{1'b0}};
      d_r         <= {WIDTH{1'b0}};
      dividend_r  <= {WIDTH{1'b0}};
      sign_q_r    <= 1'b0;
      sign_r_r    <= 1'b0;
      count_r     <= {CNT_W{1'b0}};
      calc_busy_r <= 1'b0;
      res_done_r  <= 1'b0;
      res_dbz_r   <= 1'b0;
      res_q_r     <= {WIDTH{1'b0}};
      res_rem_r   <= {WIDTH{1'b0}};
    end else begin
      res_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            rem_r       <= {WIDTH{1'b0}};
            q_r         <= magnitude(dividend, neg_a_s);
            d_r         <= magnitude(divisor, neg_b_s);
            dividend_r  <= dividend;
            sign_q_r    <= neg_a_s ^ neg_b_s;
            sign_r_r    <= neg_a_s;
            count_r     <= CNT_W'(WIDTH - 1);
            calc_busy_r <= 1'b1;
          end
        end
        CALC: begin
          rem_r <= trial_ok_s ? trial_s[WIDTH-1:0] : rem_sh_s[WIDTH-1:0];
          q_r   <= {q_r[WIDTH-2:0], trial_ok_s};
          if (count_r != {CNT_W{1'b0}}) count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
        FIX: begin
          res_q_r     <= dbz_s ? {WIDTH{1'b1}} : magnitude(q_r, sign_q_r);
          res_rem_r   <= dbz_s ? dividend_r : magnitude(rem_r, sign_r_r);
          res_dbz_r   <= dbz_s;
          res_done_r  <= 1'b1;
          calc_busy_r <= 1'b0;
        end
        default: calc_busy_r <= 1'b0;
      endcase
    end
  end

  // Output register stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= {WIDTH{1'b0}};
      remainder   <= {WIDTH{1'b0}};
      div_by_zero <= 1'b0;
    end else begin
      busy        <= calc_busy_r;
      done        <= res_done_r;
      quotient    <= res_q_r;
      remainder   <= res_rem_r;
      div_by_zero <= res_dbz_r;
    end
  end

endmodule

// File: tb/tb_seq_divider32.sv
// Self-checking bench for seq_divider32: arithmetic reference model, per-cycle output
// comparison, and directed handshake, latency, reset and corner-case vectors.
module tb_seq_divider32;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } result_t;

  result_t exp_q[$];
  result_t held;
  int      pass_cnt  = 0;
  int      total_cnt = 0;

  seq_divider32 #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_op  (signed_op),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Truncating division computed with wide signed arithmetic.
  function automatic result_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
    result_t     res;
    longint      sa, sb;
    logic [63:0] qq, rr;
    if (b == 32'd0) begin
      res.q = 32'hFFFF_FFFF;
      res.r = a;
      res.z = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      qq = 64'(sa / sb);
      rr = 64'(sa % sb);
      res.q = qq[31:0];
      res.r = rr[31:0];
      res.z = 1'b0;
    end else begin
      res.q = a / b;
      res.r = a % b;
      res.z = 1'b0;
    end
    return res;
  endfunction

  // Output checker: every cycle out of reset the outputs must equal the last completed result.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL done_unexpected: got done=1 expected no pending operation at %0t", $time);
        end else begin
          pass_cnt++;
          held = exp_q.pop_front();
        end
      end
      check("quotient", quotient, held.q);
      check("remainder", remainder, held.r);
      check("div_by_zero", {31'd0, div_by_zero}, {31'd0, held.z});
    end
  end

  task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
    signed_op = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    exp_q.push_back(model(s, a, b));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Waits for done, re-pulsing start with junk operands at cycles p1/p2 (0 = never).
  task automatic wait_done(input int p1, input int p2, output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (k == p1 || k == p2) begin
        start     = 1'b1;
        signed_op = 1'b1;
        dividend  = 32'h0000_DEAD;
        divisor   = 32'h0000_0003;
      end else begin
        start = 1'b0;
      end
      if (busy) busy_cnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b, input string tag);
    int lat, bc;
    start_op(s, a, b);
    wait_done(0, 0, lat, bc);
    check({tag, "_latency"}, lat, 32'd34);
    check({tag, "_busy_cycles"}, bc, 32'd33);
  endtask

  initial begin
    result_t m;
    int      lat, bc;
    logic [31:0] ra, rb;

    rst       = 1'b1;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = 32'd0;
    divisor   = 32'd0;
    held      = '{q: 32'd0, r: 32'd0, z: 1'b0};

    // Literal expectations that pin the reference model.
    m = model(1'b0, 32'd100, 32'd7);
    check("model_u100_7_q", m.q, 32'd14);
    check("model_u100_7_r", m.r, 32'd2);
    m = model(1'b1, 32'hFFFF_FFF9, 32'd2);
    check("model_sm7_2_q", m.q, 32'hFFFF_FFFD);
    check("model_sm7_2_r", m.r, 32'hFFFF_FFFF);
    m = model(1'b0, 32'hFFFF_FFF9, 32'd2);
    check("model_u_q", m.q, 32'h7FFF_FFFC);
    check("model_u_r", m.r, 32'd1);
    m = model(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    check("model_ovf_q", m.q, 32'h8000_0000);
    check("model_ovf_r", m.r, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_quotient", quotient, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op(1'b0, 32'd100, 32'd7, "u100_7");
    check("u100_7_q", quotient, 32'd14);
    check("u100_7_r", remainder, 32'd2);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, "sm7_2");
    check("sm7_2_q", quotient, 32'hFFFF_FFFD);
    check("sm7_2_r", remainder, 32'hFFFF_FFFF);
    run_op(1'b0, 32'hFFFF_FFF9, 32'd2, "um7_2");
    check("um7_2_q", quotient, 32'h7FFF_FFFC);
    check("um7_2_r", remainder, 32'd1);
    for (int s = 0; s < 2; s++) begin
      run_op(s[0], 32'h1234_5678, 32'd0, "dbz");
      check("dbz_q", quotient, 32'hFFFF_FFFF);
      check("dbz_r", remainder, 32'h1234_5678);
      check("dbz_flag", {31'd0, div_by_zero}, 32'd1);
    end
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "ovf");
    check("ovf_q", quotient, 32'h8000_0000);
    check("ovf_r", remainder, 32'd0);
    check("ovf_flag", {31'd0, div_by_zero}, 32'd0);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, "s7_m2");
    check("s7_m2_q", quotient, 32'hFFFF_FFFD);
    check("s7_m2_r", remainder, 32'd1);

    // Starts while busy are ignored; the checker flags any extra done.
    start_op(1'b0, 32'd1000, 32'd10);
    wait_done(5, 20, lat, bc);
    check("ignore_latency", lat, 32'd34);
    check("ignore_q", quotient, 32'd100);
    // Back-to-back start in the done cycle.
    start_op(1'b0, 32'd50, 32'd8);
    wait_done(0, 0, lat, bc);
    check("b2b_latency", lat, 32'd34);
    check("b2b_q", quotient, 32'd6);
    check("b2b_r", remainder, 32'd2);
    repeat (40) @(posedge clk);
    #1;

    // Asynchronous reset mid-operation.
    start_op(1'b0, 32'd999, 32'd4);
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    held = '{q: 32'd0, r: 32'd0, z: 1'b0};
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_q", quotient, 32'd0);
    check("arst_r", remainder, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    run_op(1'b1, 32'hFFFF_FF9C, 32'd7, "post_rst");
    check("post_rst_q", quotient, 32'hFFFF_FFF2);
    check("post_rst_r", remainder, 32'hFFFF_FFFE);

    // Random regression against the model.
    for (int i = 0; i < 150; i++) begin
      ra = $urandom;
      case (i % 4)
        0:       rb = $urandom_range(0, 15);
        1:       rb = 32'hFFFF_FFFF - $urandom_range(0, 15);
        default: rb = $urandom;
      endcase
      if (i % 7 == 0) ra = 32'h8000_0000;
      start_op(i[0], ra, rb);
      wait_done(0, 0, lat, bc);
      check("rand_latency", lat, 32'd34);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
